// File: rtl/serial_sub_mux_pkg.sv
// Shared definitions for the bit-serial subtractor.
//   state_t    : controller states (IDLE, RUN, DONE)
//   cnt_width(): width of a counter that must hold 0..w
package serial_sub_mux_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/fs_cell_mux.sv
// Combinational 1-bit full subtractor built from two 2:1 muxes selected by a.
//   a  : minuend bit
//   b  : subtrahend bit
//   c  : borrow in
//   d  : difference bit  (a ^ b ^ c)
//   bo : borrow out      (a ? b & c : b | c)
module fs_cell_mux (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic d,
  output logic bo
);

  logic bxc;

  assign bxc = b ^ c;
  assign d   = a ? ~bxc    : bxc;
  assign bo  = a ? (b & c) : (b | c);

endmodule

// File: rtl/serial_sub_mux.sv
// Bit-serial WIDTH-bit subtractor: d = a - b - bin, one bit per clock, LSB first.
//   clk, rst   : clock (rising edge), asynchronous active-high reset
//   start      : request; accepted in IDLE or DONE
//   a, b, bin  : operands, captured on an accepted start
//   busy       : high while bits are being processed
//   done       : one-cycle completion pulse
//   d, bo      : difference mod 2^WIDTH and final borrow-out
//   zero, lt   : d == 0, and a < b + bin (same as bo)
// Result outputs change only on the completing edge, so partial results
// are never visible.
module serial_sub_mux
  import serial_sub_mux_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             bo,
  output logic             zero,
  output logic             lt
);

  localparam int CW = cnt_width(WIDTH);

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic [WIDTH-1:0] res_next;
  logic             brw;
  logic [CW-1:0]    cnt;
  logic             cell_d;
  logic             cell_bo;
  logic             last_bit;

  fs_cell_mux u_cell (
    .a  (a_sr[0]),
    .b  (b_sr[0]),
    .c  (brw),
    .d  (cell_d),
    .bo (cell_bo)
  );

  // New difference bit enters at the MSB; after WIDTH shifts bit 0 sits at
  // the LSB. Shifting the concatenation keeps the expression legal for WIDTH=1.
  assign res_next = WIDTH'({cell_d, res_sr} >> 1);
  assign last_bit = (cnt == CW'(WIDTH - 1));

  // NOTE: every register here, including the operand and result shift
  // registers, is cleared by reset, and all state uses non-blocking
  // assignments so each edge sees the previous cycle's values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      brw    <= 1'b0;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      d      <= '0;
      bo     <= 1'b0;
      zero   <= 1'b0;
      lt     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sr  <= a;
            b_sr  <= b;
            brw   <= bin;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end

        RUN: begin
          res_sr <= res_next;
          brw    <= cell_bo;
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          cnt    <= cnt + CW'(1);
          if (last_bit) begin
            d     <= res_next;
            bo    <= cell_bo;
            lt    <= cell_bo;
            zero  <= ~|res_next;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end

        DONE: begin
          done <= 1'b0;
          if (start) begin
            a_sr  <= a;
            b_sr  <= b;
            brw   <= bin;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_sub_mux.sv
// Scoreboard bench for serial_sub_mux at WIDTH = 8, 1 and 16.
// Stimulus pushes the arithmetic expectation (value, flags, done cycle) into
// a per-instance queue; a negedge monitor per instance pops and compares.
module tb_serial_sub_mux;

  typedef struct packed {
    logic [15:0] d;
    logic        bo;
    logic        zero;
    logic        lt;
    int          acc;
    int          dn;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_v [3];
  logic [15:0] a_v     [3];
  logic [15:0] b_v     [3];
  logic        bin_v   [3];

  wire  [2:0]  busy_v, done_v, bo_v, zero_v, lt_v;
  wire  [7:0]  d8;
  wire         d1;
  wire  [15:0] d16;

  int   cyc    = 0;
  int   n_vec  = 0;
  int   n_bad  = 0;
  exp_t q    [3][$];
  exp_t held [3];
  int   last_dn [3];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serial_sub_mux #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst(rst), .start(start_v[0]), .a(a_v[0][7:0]), .b(b_v[0][7:0]),
    .bin(bin_v[0]), .busy(busy_v[0]), .done(done_v[0]), .d(d8), .bo(bo_v[0]),
    .zero(zero_v[0]), .lt(lt_v[0]));

  serial_sub_mux #(.WIDTH(1)) u_w1 (
    .clk(clk), .rst(rst), .start(start_v[1]), .a(a_v[1][0:0]), .b(b_v[1][0:0]),
    .bin(bin_v[1]), .busy(busy_v[1]), .done(done_v[1]), .d(d1), .bo(bo_v[1]),
    .zero(zero_v[1]), .lt(lt_v[1]));

  serial_sub_mux #(.WIDTH(16)) u_w16 (
    .clk(clk), .rst(rst), .start(start_v[2]), .a(a_v[2]), .b(b_v[2]),
    .bin(bin_v[2]), .busy(busy_v[2]), .done(done_v[2]), .d(d16), .bo(bo_v[2]),
    .zero(zero_v[2]), .lt(lt_v[2]));

  function automatic int wid(input int k);
    case (k)
      0:       return 8;
      1:       return 1;
      default: return 16;
    endcase
  endfunction

  function automatic logic [15:0] mask(input int k);
    return 16'((32'd1 << wid(k)) - 32'd1);
  endfunction

  function automatic logic [15:0] dout(input int k);
    case (k)
      0:       return {8'h00, d8};
      1:       return {15'h0000, d1};
      default: return d16;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------------------------------------------------------- monitor
  task automatic monitor_step(input int k);
    exp_t  f;
    bit    have;
    bit    exp_busy;
    string tag;
    f    = '0;
    tag  = $sformatf("w%0d", wid(k));
    have = (q[k].size() != 0);
    if (have) f = q[k][0];
    exp_busy = have && (cyc >= f.acc) && (cyc < f.dn);
    check({"busy_", tag}, busy_v[k], exp_busy);
    if (done_v[k] && !have) begin
      check({"spurious_done_", tag}, done_v[k], 1'b0);
    end else if (done_v[k]) begin
      check({"done_cycle_", tag}, cyc, f.dn);
      check({"d_", tag},    dout(k),   f.d);
      check({"bo_", tag},   bo_v[k],   f.bo);
      check({"zero_", tag}, zero_v[k], f.zero);
      check({"lt_", tag},   lt_v[k],   f.lt);
      held[k] = f;
      void'(q[k].pop_front());
    end else begin
      if (have && cyc >= f.dn) begin
        check({"done_missing_", tag}, done_v[k], 1'b1);
        void'(q[k].pop_front());
      end
      check({"d_hold_", tag},  dout(k), held[k].d);
      check({"bo_hold_", tag}, bo_v[k], held[k].bo);
    end
  endtask

  for (genvar k = 0; k < 3; k++) begin : g_mon
    always @(negedge clk) begin
      if (!rst) monitor_step(k);
    end
  end

  // --------------------------------------------------------------- stimulus
  // Called at a negedge: drives start and pushes the arithmetic expectation.
  task automatic issue(input int k, input logic [15:0] a, input logic [15:0] b,
                       input logic bin);
    exp_t        e;
    logic [15:0] m;
    logic [15:0] aa;
    logic [15:0] bb;
    longint      diff;
    m    = mask(k);
    aa   = a & m;
    bb   = b & m;
    start_v[k] = 1'b1;
    a_v[k]     = aa;
    b_v[k]     = bb;
    bin_v[k]   = bin;
    diff   = longint'(aa) - longint'(bb) - longint'(bin);
    e.d    = 16'(diff) & m;
    e.bo   = (int'(aa) < int'(bb) + int'(bin));
    e.lt   = e.bo;
    e.zero = (e.d == 16'h0000);
    e.acc  = cyc + 1;
    e.dn   = cyc + 1 + wid(k);
    q[k].push_back(e);
    last_dn[k] = e.dn;
  endtask

  // Drops start after acceptance, scrambles the inputs, optionally pulses start
  // mid-RUN, and returns at the negedge of the DONE cycle.
  task automatic finish_op(input int k, input bit mid_start);
    int guard;
    guard = 0;
    @(negedge clk);
    start_v[k] = 1'b0;
    a_v[k]     = 16'($urandom);
    b_v[k]     = 16'($urandom);
    bin_v[k]   = 1'($urandom);
    if (mid_start && wid(k) >= 3) begin
      @(negedge clk);
      start_v[k] = 1'b1;
      @(negedge clk);
      start_v[k] = 1'b0;
    end
    while (cyc < last_dn[k] && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) check("op_timeout", cyc, last_dn[k]);
  endtask

  // gap = 0 issues the next op straight from DONE (back-to-back).
  task automatic run(input int k, input logic [15:0] a, input logic [15:0] b,
                     input logic bin, input bit mid_start, input int gap);
    issue(k, a, b, bin);
    finish_op(k, mid_start);
    repeat (gap) @(negedge clk);
  endtask

  task automatic clear_model();
    for (int k = 0; k < 3; k++) begin
      q[k].delete();
      held[k] = '0;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: bench did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    for (int k = 0; k < 3; k++) begin
      start_v[k] = 1'b0;
      a_v[k]     = '0;
      b_v[k]     = '0;
      bin_v[k]   = 1'b0;
    end
    clear_model();
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check("rst_busy", busy_v[k], 1'b0);
      check("rst_done", done_v[k], 1'b0);
      check("rst_d",    dout(k),   16'h0000);
      check("rst_flags", {bo_v[k], zero_v[k], lt_v[k]}, 3'b000);
    end
    rst = 1'b0;
    @(negedge clk);

    // WIDTH=8 directed, including a mid-RUN start pulse and scrambled inputs.
    run(0, 16'h5A, 16'h3C, 1'b0, 1'b1, 1);
    run(0, 16'h00, 16'h01, 1'b0, 1'b0, 1);
    run(0, 16'h80, 16'h7F, 1'b1, 1'b1, 2);
    // Back-to-back: done must land every 9 cycles.
    run(0, 16'h5A, 16'h3C, 1'b0, 1'b0, 0);
    run(0, 16'hFF, 16'hFF, 1'b1, 1'b0, 0);
    run(0, 16'h5A, 16'h3C, 1'b0, 1'b0, 2);

    // Reset during RUN cycle 4 of a new op: outputs clear at once, no done.
    issue(0, 16'h11, 16'h22, 1'b1);
    @(negedge clk);
    start_v[0] = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_rst_d",    {8'h00, d8}, 16'h0000);
    check("async_rst_busy", busy_v[0],   1'b0);
    check("async_rst_done", done_v[0],   1'b0);
    check("async_rst_flags", {bo_v[0], zero_v[0], lt_v[0]}, 3'b000);
    clear_model();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run(0, 16'h5A, 16'h3C, 1'b0, 1'b0, 1);

    // WIDTH=1 exhaustive truth table, alternating back-to-back and gapped.
    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      v = 3'(i);
      run(1, {15'h0, v[2]}, {15'h0, v[1]}, v[0], 1'b0, i % 2);
    end

    // WIDTH=16 directed corner.
    run(2, 16'h0000, 16'hFFFF, 1'b1, 1'b0, 1);
    run(2, 16'hFFFF, 16'h0000, 1'b0, 1'b1, 0);

    // Randomised traffic on the multi-bit instances.
    for (int k = 0; k < 3; k += 2) begin
      repeat (25) begin
        run(k, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom),
            int'($urandom_range(2, 0)));
      end
    end

    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) check("scoreboard_drained", q[k].size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/serial_sub_mux.md
Name: serial_sub_mux

Overview:
- Parametrised bit-serial N-bit subtractor: computes a - b - bin one bit per clock, LSB first.
- Built around a single mux-based 1-bit full-subtractor cell.
- Produces difference, borrow-out, zero and less-than flags with a start/busy/done handshake.
- Sits beside the combinational subtractor/comparator cells as the area-cheap multi-bit arithmetic/compare unit.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range >= 1.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  request; sampled at rising clk edge.
- a  input  WIDTH  minuend; captured on accepted start.
- b  input  WIDTH  subtrahend; captured on accepted start.
- bin  input  1  borrow-in; captured on accepted start.
- busy  output  1  high while bits are being processed.
- done  output  1  one-cycle completion pulse.
- d  output  WIDTH  difference (a - b - bin) mod 2^WIDTH.
- bo  output  1  final borrow-out.
- zero  output  1  high when d == 0.
- lt  output  1  high when a < b + bin (unsigned); equals bo.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: state=IDLE, busy=0, done=0, d=0, bo=0, zero=0, lt=0. Internal shift registers, borrow register and counter are cleared.
- States are IDLE, RUN and DONE.
- IDLE: busy=0, done=0. start=1 at an edge latches a, b and bin into operand shift registers and the borrow register, clears the bit counter, and moves to RUN.
- RUN: busy=1. Each edge feeds the operand LSBs and the borrow register into the cell:
  - cell difference is shifted into the result shadow register from the MSB side;
  - cell borrow goes to the borrow register;
  - operands shift right by one;
  - counter increments.
- RUN -> DONE: on the edge where the counter reaches WIDTH-1 (i.e. the WIDTH-th bit). That edge also commits d, bo, zero and lt.
- DONE: busy=0, done=1 for exactly one cycle. At the next edge:
  - start=1: accept new operands and go to RUN (back-to-back operation);
  - otherwise: go to IDLE.
- Latency: start sampled at edge 0; busy=1 after edges 0..WIDTH-1; done=1 after edge WIDTH. Throughput is one result per WIDTH+1 cycles.
- start while in RUN is ignored. Operands are not re-sampled and the counter is unaffected.
- a, b and bin are sampled only on acceptance. Later input changes have no effect on the operation in flight.
- d, bo, zero and lt hold their last committed values through IDLE and RUN. They update only on the completing edge, so the bus never shows partial results.
- Cell truth (a_i, b_i, c -> d_i, bo_i):
  - d_i = a_i ^ b_i ^ c;
  - bo_i = b_i|c when a_i=0;
  - bo_i = b_i&c when a_i=1.
- Wrap-around: results are modulo 2^WIDTH; underflow is signalled only through bo/lt.
- Counter width is $clog2(WIDTH+1). For WIDTH=1 the RUN state lasts exactly one cycle.
- Reset asserted mid-operation aborts the operation. All outputs return to reset values; no done pulse is produced.

Decomposition:
- Shared package:
  - state enum (IDLE=2'd0, RUN=2'd1, DONE=2'd2);
  - counter-width helper function.
- One sub-module, fs_cell_mux: a combinational 1-bit full subtractor.
  - Ports: a, b, c, d, bo.
  - Each output is produced by a 2:1 mux selected by a.
  - The top level instantiates it exactly once.

Test Plan:
- WIDTH=8, a=0x5A, b=0x3C, bin=0, start at edge 0 -> done=1 after edge 8; d=0x1E, bo=0, zero=0, lt=0; busy high for 8 cycles.
- WIDTH=8, a=0x00, b=0x01, bin=0 -> d=0xFF, bo=1, lt=1, zero=0. Then a=0x80, b=0x7F, bin=1 -> d=0x00, zero=1, bo=0, lt=0.
- Start pulsed again mid-RUN, and a/b toggled after acceptance -> result unchanged (0x1E case). Start held high in DONE -> new op begins with no IDLE cycle; done pulses every 9 cycles.
- After a completed op (d=0x1E), assert rst at RUN cycle 4 of a new op -> all outputs 0 asynchronously, no done; the next op after release completes correctly.
- WIDTH=1, exhaustive 8 combinations of a, b, bin -> d/bo match the full-subtractor truth table; done after edge 1.
- WIDTH=16, a=0x0000, b=0xFFFF, bin=1 -> d=0x0000, bo=1, zero=1, lt=1.
